// File: rtl/mul_exec_unit.sv
// mul_exec_unit
// Iterative shift-add multiplier for the execute stage. It sits beside the
// single-cycle ALU and covers MUL, UMULH and SMULH. Each operation takes
// exactly N iterations. Control stalls the PC while busy is high.
//
// Ports
//   clk        clock; all state updates on posedge
//   reset      synchronous, active-low reset
//   start      request; accepted only in IDLE or DONE
//   op         00=MUL (low half), 01=UMULH (high, unsigned),
//              10=SMULH (high, signed), 11=treated as MUL
//   a, b       multiplicand / multiplier (ALU operand buses)
//   busy       high while iterating (exactly N cycles)
//   done       one-cycle pulse when result is valid
//   result     selected product half, held until replaced by the next op
//   zero       result == 0 (same meaning as the ALU zero flag)
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: start is sampled on a posedge while state is IDLE or DONE.
// busy rises from that edge and stays high for N cycles. done is high for
// the single cycle that follows. start seen while busy is dropped.

module mul_exec_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);
    localparam logic [N-1:0]   ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N   = {{(2*N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   mcand, mlier;
    logic [2*N-1:0] prod;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic           neg_q;

    logic           accept, last, high_half, smulh;
    logic [N:0]     sum;
    logic [2*N-1:0] prod_step, prod_fin;
    logic [N-1:0]   res_fin, abs_a, abs_b;

    assign accept = start && (state != S_RUN);
    assign last   = (cnt == LAST_CNT);
    assign smulh  = (op == 2'b10);

    // Magnitudes for SMULH. -2^(N-1) maps to 2^(N-1), which still fits
    // in N unsigned bits, so no special case is needed.
    assign abs_a = a[N-1] ? (~a + ONE_N) : a;
    assign abs_b = b[N-1] ? (~b + ONE_N) : b;

    // One shift-add step: add into the upper half with an N+1-bit carry,
    // then shift {carry, product} right by one.
    always_comb begin
        sum       = {1'b0, prod[2*N-1:N]} + {1'b0, (mlier[0] ? mcand : {N{1'b0}})};
        prod_step = {sum, prod[N-1:1]};
        prod_fin  = neg_q ? (~prod_step + ONE_2N) : prod_step;
        high_half = (op_q == 2'b01) || (op_q == 2'b10);
        res_fin   = high_half ? prod_fin[2*N-1:N] : prod_fin[N-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last)   state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mlier  <= '0;
            prod   <= '0;
            cnt    <= '0;
            op_q   <= 2'b00;
            neg_q  <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op;
                mcand <= smulh ? abs_a : a;
                mlier <= smulh ? abs_b : b;
                neg_q <= smulh && (a[N-1] ^ b[N-1]);
                prod  <= '0;
                cnt   <= '0;
            end else if (state == S_RUN) begin
                mlier <= mlier >> 1;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    prod   <= prod_fin;
                    result <= res_fin;
                    zero   <= (res_fin == '0);
                end else begin
                    prod <= prod_step;
                end
            end
        end
    end

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mul_exec_unit.sv
module tb_mul_exec_unit;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done, zero;
  logic [N-1:0] result;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  mul_exec_unit #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse from a negedge; returns just after the accepting edge.
  task automatic do_start(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    op    = 2'($urandom_range(0, 3));
  endtask

  // Wait (bounded) for done; checks latency, busy length, result and zero.
  // When inject is set, a start with fresh operands is pulsed mid-run.
  task automatic wait_done(input string tag, input logic [N-1:0] exp_res,
                           input logic exp_zero, input bit inject);
    int cyc = 0;
    int busy_cyc = 0;
    bit seen = 0;
    while (cyc < N + 8 && !seen) begin
      @(negedge clk);
      cyc++;
      if (inject && cyc == 10) begin
        start = 1'b1;
        op    = 2'b00;
        a     = 64'd5;
        b     = 64'd5;
      end else if (inject && cyc == 11) begin
        start = 1'b0;
      end
      if (busy) busy_cyc++;
      if (done) seen = 1;
    end
    check({tag, "_latency"}, N'(cyc), N'(N + 1));
    check({tag, "_busy_cycles"}, N'(busy_cyc), N'(N));
    check({tag, "_done"}, N'(done), N'(1));
    check({tag, "_busy_at_done"}, N'(busy), N'(0));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, N'(zero), N'(exp_zero));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", N'(busy), N'(0));
    check("rst_done", N'(done), N'(0));
    check("rst_result", result, '0);
    check("rst_zero", N'(zero), N'(1));
    check("rst_state", N'(dbg_state), N'(0));
    reset = 1'b1;
    @(negedge clk);

    // 1. basic MUL, then done must be a single-cycle pulse
    do_start(2'b00, 64'd10, 64'd7);
    wait_done("mul_10x7", 64'd70, 1'b0, 0);
    @(negedge clk);
    check("done_pulse_width", N'(done), N'(0));
    check("idle_state", N'(dbg_state), N'(0));
    check("result_held", result, 64'd70);

    // 2. a=-10, b=-2, issued back-to-back from DONE
    do_start(2'b00, -64'sd10, -64'sd2);
    wait_done("mul_m10xm2", 64'd20, 1'b0, 0);
    do_start(2'b10, -64'sd10, -64'sd2);
    wait_done("smulh_m10xm2", 64'd0, 1'b1, 0);
    do_start(2'b01, -64'sd10, -64'sd2);
    wait_done("umulh_m10xm2", 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 0);

    // 3. a=b=-1
    do_start(2'b01, '1, '1);
    wait_done("umulh_m1xm1", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0);
    do_start(2'b00, '1, '1);
    wait_done("mul_m1xm1", 64'd1, 1'b0, 0);
    do_start(2'b10, '1, '1);
    wait_done("smulh_m1xm1", 64'd0, 1'b1, 0);

    // 4. a=-10, b=7
    do_start(2'b00, -64'sd10, 64'd7);
    wait_done("mul_m10x7", 64'hFFFF_FFFF_FFFF_FFBA, 1'b0, 0);
    do_start(2'b10, -64'sd10, 64'd7);
    wait_done("smulh_m10x7", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);

    // boundaries: most-negative SMULH, reserved op, UMULH carry out
    do_start(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    wait_done("smulh_min", 64'h4000_0000_0000_0000, 1'b0, 0);
    do_start(2'b11, 64'd10, 64'd7);
    wait_done("op11_as_mul", 64'd70, 1'b0, 0);
    do_start(2'b01, 64'h8000_0000_0000_0000, 64'd2);
    wait_done("umulh_carry", 64'd1, 1'b0, 0);

    // 5. zero product; start mid-run must be ignored
    @(negedge clk);
    do_start(2'b00, 64'd0, 64'h1234);
    wait_done("mul_zero_inject", 64'd0, 1'b1, 1);
    @(negedge clk);
    check("inject_no_rerun", N'(busy), N'(0));

    // load a nonzero result so the reset clear is visible
    do_start(2'b00, 64'd3, 64'd4);
    wait_done("mul_3x4", 64'd12, 1'b0, 0);

    // 6. reset at cycle 20 of a run
    @(negedge clk);
    do_start(2'b00, 64'd9, 64'd9);
    repeat (20) @(negedge clk);
    check("pre_abort_busy", N'(busy), N'(1));
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", N'(busy), N'(0));
    check("abort_done", N'(done), N'(0));
    check("abort_result", result, '0);
    check("abort_zero", N'(zero), N'(1));
    reset = 1'b1;
    begin
      int late_done = 0;
      for (int i = 0; i < N + 8; i++) begin
        @(negedge clk);
        if (done || busy) late_done++;
      end
      check("abort_no_done", N'(late_done), N'(0));
    end
    do_start(2'b00, 64'd6, 64'd7);
    wait_done("after_abort", 64'd42, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
